// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states and
// transaction owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store. Load/store normally wins,
// but a saturating starvation counter forces a fetch grant after STARVE_MAX
// consecutive load/store grants made while fetch was waiting.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic       ls_req,
  input  logic       arb_en,
  output arb_owner_t winner
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             if_forced;

  // Pick the winner; fetch is forced through once its wait has saturated
  always_comb begin
    if_forced = if_req && (starve_q == CNT_MAX);
    winner    = OWN_NONE;
    if (arb_en) begin
      if (ls_req && !if_forced) begin
        winner = OWN_LS;
      end else if (if_req) begin
        winner = OWN_IF;
      end
    end
  end

  // Count load/store grants that bypassed a waiting fetch; clear once fetch is served or idle
  always_comb begin
    starve_d = starve_q;
    if (arb_en) begin
      if (!if_req || (winner == OWN_IF)) begin
        starve_d = '0;
      end else if ((winner == OWN_LS) && (starve_q != CNT_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported unified memory between instruction fetch and
// load/store. Each access is sequenced by a small FSM that counts the fixed
// read latency and returns a one-cycle done pulse to the owning requester.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  arb_owner_t        winner;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic              read_last;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .ls_req (ls_req),
    .arb_en (state_q == IDLE),
    .winner (winner)
  );

  // State, owner, latency counter and memory-side registers; reset aborts any access at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      lat_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_q       <= lat_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  // Next-state: arbitrate in IDLE, capture the winner's access, then count down the read latency
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_d       = lat_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        owner_d = winner;
        if (winner == OWN_IF) begin
          mem_addr_d = if_addr;
          lat_d      = LAT_INIT;
          state_d    = READ;
        end else if (winner == OWN_LS) begin
          mem_addr_d  = ls_addr;
          mem_wdata_d = ls_wdata;
          if (ls_we) begin
            mem_wr_d = 1'b1;
            state_d  = WRITE;
          end else begin
            lat_d   = LAT_INIT;
            state_d = READ;
          end
        end
      end
      READ: begin
        if (lat_q != '0) begin
          lat_d = lat_q - 1'b1;
        end
        if (lat_q == LAT_LAST) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: done goes only to the owner, in the last read cycle or the single write cycle
  always_comb begin
    read_last = (state_q == READ) && (lat_q == LAT_LAST);
    if_done   = read_last && (owner_q == OWN_IF);
    ls_done   = ((read_last || (state_q == WRITE)) && (owner_q == OWN_LS));
    busy      = (state_q != IDLE);
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed fetch/load/store
// transactions push expected results into per-requester queues, and
// monitors pop and compare whenever a done pulse appears.
module tb_mem_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_if_req, a_if_done, a_ls_req, a_ls_we, a_ls_done, a_mem_wr, a_busy;
  logic [31:0] a_if_addr, a_if_rdata, a_ls_addr, a_ls_wdata, a_ls_rdata;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata, a_pipe;

  logic        b_if_req, b_if_done, b_ls_req, b_ls_we, b_ls_done, b_mem_wr, b_busy;
  logic [31:0] b_if_addr, b_if_rdata, b_ls_addr, b_ls_wdata, b_ls_rdata;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  exp_t ifq[$];
  exp_t lsq[$];
  exp_t bq[$];
  exp_t ea, el, eb;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_done(a_if_done), .if_rdata(a_if_rdata),
    .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_addr(a_ls_addr), .ls_wdata(a_ls_wdata),
    .ls_done(a_ls_done), .ls_rdata(a_ls_rdata),
    .mem_addr(a_mem_addr), .mem_wr(a_mem_wr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_done(b_if_done), .if_rdata(b_if_rdata),
    .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
    .ls_done(b_ls_done), .ls_rdata(b_ls_rdata),
    .mem_addr(b_mem_addr), .mem_wr(b_mem_wr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  always #5 clk = ~clk;

  // Cycle index used for expected done timing
  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by both arbiters
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'h0000_0013;
      32'h0000_0004: mem_word = 32'h0010_0093;
      32'h0000_0010: mem_word = 32'h0050_0093;
      32'h0000_0020: mem_word = 32'hA0A0_0020;
      32'h0000_0024: mem_word = 32'hA0A0_0024;
      32'h0000_0028: mem_word = 32'hA0A0_0028;
      32'h0000_002C: mem_word = 32'hA0A0_002C;
      32'h0000_0030: mem_word = 32'hA0A0_0030;
      32'h0000_0034: mem_word = 32'hA0A0_0034;
      default:       mem_word = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Two-cycle memory for dut_a: data appears one cycle after the address register
  always @(posedge clk) a_pipe <= mem_word(a_mem_addr);
  assign a_mem_rdata = a_pipe;
  // Single-cycle memory for dut_b: data valid in the same cycle as the address
  assign b_mem_rdata = mem_word(b_mem_addr);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("[TB] FAIL %s: got a done pulse, expected none", name);
  endtask

  // Monitor for dut_a: invariants every cycle, scoreboard compare on each done pulse
  always @(negedge clk) begin
    checkOutput("a_done_exclusive", {31'b0, a_if_done & a_ls_done}, 32'h0);
    checkOutput("a_mem_wr_only_on_store", {31'b0, a_mem_wr & ~a_ls_done}, 32'h0);
    if (a_if_done) begin
      if (ifq.size() == 0) begin
        unexpected("a_if_done");
      end else begin
        ea = ifq.pop_front();
        checkOutput("a_if_rdata", a_if_rdata, ea.data);
        checkOutput("a_if_cycle", 32'(cyc), 32'(ea.cyc));
        checkOutput("a_if_mem_addr", a_mem_addr, ea.addr);
        checkOutput("a_if_mem_wr", {31'b0, a_mem_wr}, 32'h0);
      end
    end
    if (a_ls_done) begin
      if (lsq.size() == 0) begin
        unexpected("a_ls_done");
      end else begin
        el = lsq.pop_front();
        checkOutput("a_ls_cycle", 32'(cyc), 32'(el.cyc));
        checkOutput("a_ls_mem_addr", a_mem_addr, el.addr);
        checkOutput("a_ls_mem_wr", {31'b0, a_mem_wr}, {31'b0, el.we});
        if (el.we) begin
          checkOutput("a_ls_mem_wdata", a_mem_wdata, el.data);
        end else begin
          checkOutput("a_ls_rdata", a_ls_rdata, el.data);
        end
      end
    end
  end

  // Monitor for dut_b: fetch-only traffic
  always @(negedge clk) begin
    checkOutput("b_ls_done_never", {31'b0, b_ls_done}, 32'h0);
    checkOutput("b_ls_rdata_pass", b_ls_rdata, b_mem_rdata);
    if (b_if_done) begin
      if (bq.size() == 0) begin
        unexpected("b_if_done");
      end else begin
        eb = bq.pop_front();
        checkOutput("b_if_rdata", b_if_rdata, eb.data);
        checkOutput("b_if_cycle", 32'(cyc), 32'(eb.cyc));
        checkOutput("b_if_mem_addr", b_mem_addr, eb.addr);
        checkOutput("b_if_mem_wr", {31'b0, b_mem_wr}, 32'h0);
      end
    end
  end

  // Wait (bounded) for a requester's done, then step to the following cycle and expect IDLE
  task automatic wait_done(input int which, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = a_if_done;
        1:       seen = a_ls_done;
        default: seen = b_if_done;
      endcase
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got no done in 40 cycles, expected a done pulse", name);
    end
    @(posedge clk);
    #1;
    checkOutput({name, "_busy_after"}, {31'b0, (which == 2) ? b_busy : a_busy}, 32'h0);
  endtask

  task automatic fetch_a(input logic [31:0] addr, input logic [31:0] data, input int off);
    a_if_req  = 1'b1;
    a_if_addr = addr;
    ifq.push_back('{addr, 1'b0, data, cyc + off});
    wait_done(0, "a_fetch");
    a_if_req = 1'b0;
  endtask

  // Load/store leaves ls_req high so the caller can chain a new transaction
  task automatic ls_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] data, input int off);
    a_ls_req   = 1'b1;
    a_ls_we    = we;
    a_ls_addr  = addr;
    a_ls_wdata = wdata;
    lsq.push_back('{addr, we, we ? wdata : data, cyc + off});
    wait_done(1, "a_ls");
  endtask

  task automatic fetch_b(input logic [31:0] addr, input logic [31:0] data, input int off);
    b_if_req  = 1'b1;
    b_if_addr = addr;
    bq.push_back('{addr, 1'b0, data, cyc + off});
    wait_done(2, "b_fetch");
    b_if_req = 1'b0;
  endtask

  task automatic applyStimulus();
    // Plain fetch: done two cycles after the request
    fetch_a(32'h10, 32'h0050_0093, 2);

    // Store: single write cycle one cycle after the request
    ls_a(1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0, 1);
    a_ls_req = 1'b0;
    a_ls_we  = 1'b0;

    // Collision: load served first, fetch picked up at the next IDLE
    fork
      fetch_a(32'h4, 32'h0010_0093, 5);
      begin
        ls_a(1'b0, 32'h20, 32'h0, 32'hA0A0_0020, 2);
        a_ls_req = 1'b0;
      end
    join

    // Starvation: four loads, then the forced fetch, then loads resume
    fork
      fetch_a(32'h10, 32'h0050_0093, 14);
      begin
        ls_a(1'b0, 32'h20, 32'h0, 32'hA0A0_0020, 2);
        ls_a(1'b0, 32'h24, 32'h0, 32'hA0A0_0024, 2);
        ls_a(1'b0, 32'h28, 32'h0, 32'hA0A0_0028, 2);
        ls_a(1'b0, 32'h2C, 32'h0, 32'hA0A0_002C, 2);
        ls_a(1'b0, 32'h30, 32'h0, 32'hA0A0_0030, 5);
        ls_a(1'b0, 32'h34, 32'h0, 32'hA0A0_0034, 2);
        a_ls_req = 1'b0;
      end
    join

    // Reset in the first READ cycle: abort, then the held fetch completes after release
    a_if_req  = 1'b1;
    a_if_addr = 32'h10;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", {31'b0, a_busy}, 32'h0);
    checkOutput("rst_mid_mem_wr", {31'b0, a_mem_wr}, 32'h0);
    checkOutput("rst_mid_if_done", {31'b0, a_if_done}, 32'h0);
    checkOutput("rst_mid_mem_addr", a_mem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ifq.push_back('{32'h10, 1'b0, 32'h0050_0093, cyc + 2});
    wait_done(0, "a_fetch_after_rst");
    a_if_req = 1'b0;

    // RD_LAT=1: back-to-back fetches with done pulses two cycles apart
    fetch_b(32'h0, 32'h0000_0013, 1);
    fetch_b(32'h4, 32'h0010_0093, 1);
  endtask

  // Safety net in case something blocks outside the bounded waits
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, directed traffic, drain check, summary
  initial begin
    a_if_req = 1'b0; a_if_addr = '0; a_ls_req = 1'b0; a_ls_we = 1'b0;
    a_ls_addr = '0; a_ls_wdata = '0;
    b_if_req = 1'b0; b_if_addr = '0; b_ls_req = 1'b0; b_ls_we = 1'b0;
    b_ls_addr = '0; b_ls_wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'b0, a_busy}, 32'h0);
    checkOutput("rst_mem_wr", {31'b0, a_mem_wr}, 32'h0);
    checkOutput("rst_mem_addr", a_mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", a_mem_wdata, 32'h0);
    checkOutput("rst_if_done", {31'b0, a_if_done}, 32'h0);
    checkOutput("rst_ls_done", {31'b0, a_ls_done}, 32'h0);
    checkOutput("rst_b_busy", {31'b0, b_busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("queues_drained", 32'(ifq.size() + lsq.size() + bq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
